// File: rtl/unidade_controle_contagem.sv
// Control unit for a 4-bit load/count datapath: sequences clear, optional load,
// pausable counting and a completion pulse, with run statistics for debug.
module unidade_controle_contagem (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       modo,
  input  logic       pausa,
  input  logic       fim,
  input  logic       igual,
  output logic       zera,
  output logic       carrega,
  output logic       conta,
  output logic       pronto,
  output logic       passou_igual,
  output logic [4:0] db_ciclos,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'b0000,
    PREPARACAO = 4'b0001,
    CARGA      = 4'b0010,
    CONTAGEM   = 4'b0011,
    PAUSADO    = 4'b0100,
    FINAL      = 4'b0101
  } estado_t;

  estado_t    state_reg;
  estado_t    state_next;
  logic       modo_reg;
  logic [4:0] ciclos_reg;
  logic       passou_reg;

  always_comb begin
    state_next = INICIAL;
    case (state_reg)
      INICIAL:    state_next = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: state_next = modo_reg ? CARGA : CONTAGEM;
      CARGA:      state_next = CONTAGEM;
      // fim wins over pausa so a run never stalls on its last count
      CONTAGEM:   state_next = fim ? FINAL : (pausa ? PAUSADO : CONTAGEM);
      PAUSADO:    state_next = pausa ? PAUSADO : CONTAGEM;
      FINAL:      state_next = INICIAL;
      default:    state_next = INICIAL;
    endcase
  end

  // Commands are registered from the next state, so they always match state_reg
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= INICIAL;
      modo_reg   <= 1'b0;
      ciclos_reg <= 5'd0;
      passou_reg <= 1'b0;
      zera       <= 1'b0;
      carrega    <= 1'b0;
      conta      <= 1'b0;
      pronto     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == INICIAL && iniciar) begin
        modo_reg <= modo;
      end
      if (state_reg == PREPARACAO) begin
        ciclos_reg <= 5'd0;
        passou_reg <= 1'b0;
      end else if (state_reg == CONTAGEM) begin
        if (ciclos_reg != 5'd31) begin
          ciclos_reg <= ciclos_reg + 5'd1;
        end
        if (igual) begin
          passou_reg <= 1'b1;
        end
      end
      zera    <= (state_next == PREPARACAO);
      carrega <= (state_next == CARGA);
      conta   <= (state_next == CONTAGEM);
      pronto  <= (state_next == FINAL);
    end
  end

  assign passou_igual = passou_reg;
  assign db_ciclos    = ciclos_reg;
  assign db_estado    = state_reg;

endmodule

// File: tb/tb_unidade_controle_contagem.sv
// Bench for unidade_controle_contagem: a 4-bit counter/comparator datapath model,
// a run-level planner that queues expected outputs, and a per-cycle monitor.
module tb_unidade_controle_contagem;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       modo = 1'b0;
  logic       pausa = 1'b0;
  logic       fim;
  logic       igual;
  logic       zera, carrega, conta, pronto, passou_igual;
  logic [4:0] db_ciclos;
  logic [3:0] db_estado;

  logic [3:0] chaves = 4'd0;
  logic       fim_en = 1'b1;
  logic [3:0] q_dp = 4'd0;

  localparam logic [3:0] S_INI = 4'd0, S_PREP = 4'd1, S_CARGA = 4'd2;
  localparam logic [3:0] S_CONT = 4'd3, S_PAUS = 4'd4, S_FIM = 4'd5;
  localparam logic [3:0] C_NONE = 4'b0000, C_ZERA = 4'b1000, C_CARREGA = 4'b0100;
  localparam logic [3:0] C_CONTA = 4'b0010, C_PRONTO = 4'b0001;

  unidade_controle_contagem dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .pausa(pausa),
    .fim(fim), .igual(igual), .zera(zera), .carrega(carrega), .conta(conta),
    .pronto(pronto), .passou_igual(passou_igual), .db_ciclos(db_ciclos),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Datapath model: fim_en lets the bench mask the carry to force long runs
  always @(posedge clock) begin
    if (reset)        q_dp <= 4'd0;
    else if (zera)    q_dp <= 4'd0;
    else if (carrega) q_dp <= chaves;
    else if (conta)   q_dp <= q_dp + 4'd1;
  end
  assign fim   = conta && (q_dp == 4'hF) && fim_en;
  assign igual = (q_dp == chaves);

  typedef struct {
    int          cyc;
    int          scen;
    logic [13:0] v;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int cur_scen = 0;
  bit [4:0] m_ciclos = 5'd0;
  bit       m_passou = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus; expects the given state/commands after the next edge
  task automatic step(input bit rst, input bit ini, input bit md, input bit pa,
                      input bit fe, input logic [3:0] est, input logic [3:0] cmd);
    exp_t e;
    @(posedge clock);
    #2;
    reset = rst; iniciar = ini; modo = md; pausa = pa; fim_en = fe;
    e.cyc  = cyc + 1;
    e.scen = cur_scen;
    e.v    = {est, cmd, m_passou, m_ciclos};
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    m_ciclos = 5'd0;
    m_passou = 1'b0;
    step(1'b1, rb(), rb(), rb(), 1'b1, S_INI, C_NONE);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rb(), rb(), 1'b1, S_INI, C_NONE);
  endtask

  // One complete run: pause of plen cycles raised when Q==pq, reset injected at
  // the abort_at-th counting cycle, carry masked for the first nofim counts.
  task automatic run(input bit md, input logic [3:0] ch, input int pq, input int plen,
                     input bit hold, input int abort_at, input int nofim, input int scen);
    int q;
    int n;
    bit pdone;
    bit pa;
    bit fe;
    cur_scen = scen;
    chaves = ch;
    step(1'b0, 1'b1, md, rb(), 1'b1, S_PREP, C_ZERA);
    m_ciclos = 5'd0;
    m_passou = 1'b0;
    if (md) begin
      step(1'b0, hold, rb(), rb(), 1'b1, S_CARGA, C_CARREGA);
      step(1'b0, hold, rb(), rb(), 1'b1, S_CONT, C_CONTA);
      q = int'(ch);
    end else begin
      step(1'b0, hold, rb(), rb(), 1'b1, S_CONT, C_CONTA);
      q = 0;
    end
    n = 0;
    pdone = 1'b0;
    forever begin
      if (n == abort_at) begin
        do_reset();
        return;
      end
      fe = (n >= nofim);
      pa = !pdone && (q == pq) && (plen > 0);
      if (m_ciclos != 5'd31) m_ciclos = m_ciclos + 5'd1;
      if (q == int'(ch)) m_passou = 1'b1;
      if (q == 15 && fe) begin
        step(1'b0, hold, rb(), pa, fe, S_FIM, C_PRONTO);
        break;
      end
      n++;
      if (pa) begin
        pdone = 1'b1;
        for (int i = 0; i < plen; i++) step(1'b0, hold, rb(), 1'b1, fe, S_PAUS, C_NONE);
        step(1'b0, hold, rb(), 1'b0, fe, S_CONT, C_CONTA);
      end else begin
        step(1'b0, hold, rb(), 1'b0, fe, S_CONT, C_CONTA);
      end
      q = (q + 1) % 16;
    end
    step(1'b0, hold, rb(), rb(), 1'b1, S_INI, C_NONE);
  endtask

  // Monitor: compares the whole output bundle whenever an expectation is due
  initial begin
    exp_t e;
    logic [13:0] act;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL scen%0d stale expectation for cycle %0d at cycle %0d", e.scen, e.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        act = {db_estado, zera, carrega, conta, pronto, passou_igual, db_ciclos};
        vectors++;
        if (act !== e.v) begin
          miscompares++;
          $display("FAIL scen%0d cycle %0d: got estado=%h zcap=%b passou=%b ciclos=%0d, want estado=%h zcap=%b passou=%b ciclos=%0d",
                   e.scen, cyc, act[13:10], act[9:6], act[5], act[4:0],
                   e.v[13:10], e.v[9:6], e.v[5], e.v[4:0]);
        end
      end
    end
  end

  initial begin
    cur_scen = 0;
    do_reset();
    do_reset();
    idle(3);
    run(1'b0, 4'd9,  -1, 0, 1'b0, 1000, 0, 1);   // plain count from 0
    idle(2);
    run(1'b1, 4'd12, -1, 0, 1'b0, 1000, 0, 2);   // load 12, count 4
    idle(1);
    run(1'b0, 4'd3,   4, 3, 1'b0, 1000, 0, 3);   // pause holds Q at 5
    run(1'b0, 4'd6,  -1, 0, 1'b1, 1000, 0, 4);   // iniciar held high
    run(1'b1, 4'd10, -1, 0, 1'b0, 1000, 0, 5);   // back-to-back restart
    idle(2);
    run(1'b0, 4'd5,  -1, 0, 1'b0, 7,    0, 6);   // reset at Q=7
    idle(2);
    run(1'b0, 4'd0,  15, 2, 1'b0, 1000, 0, 7);   // pausa together with fim
    idle(1);
    run(1'b0, 4'd2,  -1, 0, 1'b0, 1000, 40, 8);  // counter saturation
    idle(1);
    for (int r = 0; r < 25; r++) begin
      int pq;
      int ab;
      pq = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : 1000;
      run(rb(), 4'($urandom_range(0, 15)), pq, int'($urandom_range(1, 4)), rb(), ab, 0, 100 + r);
      idle(int'($urandom_range(0, 3)));
    end
    repeat (4) @(negedge clock);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
